// File: rtl/branch_predictor.sv
// branch_predictor: BTB + 2-bit counter predictor with static, bimodal and gshare modes
module branch_predictor #(
    parameter int ENTRIES   = 32,
    parameter int HIST_BITS = 5,
    parameter int MODE      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          if_pc,
    input  logic                 stall,
    output logic                 pred_taken,
    output logic [31:0]          pred_pc,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_is_cond,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic [HIST_BITS-1:0] upd_ghr,
    input  logic                 upd_mispredict
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;
    logic [ENTRIES-1:0]   valid;
    logic [ENTRIES-1:0]   is_cond;
    logic [TW-1:0]        tag [ENTRIES];
    logic [31:0]          target [ENTRIES];
    logic [1:0]           cnt [ENTRIES];
    logic [HIST_BITS-1:0] ghr, ghr_next;
    logic [IDX-1:0]       bidx, cidx, widx, uidx;
    logic                 hit, hit_cond;
    logic                 unused_bits;
    assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
    assign bidx = if_pc[IDX+1:2];
    assign widx = upd_pc[IDX+1:2];
    assign cidx = bidx ^ (MODE == 2 ? IDX'(ghr) : '0);
    assign uidx = widx ^ (MODE == 2 ? IDX'(upd_ghr) : '0);
    assign hit = valid[bidx] && tag[bidx] == if_pc[31:IDX+2];
    assign hit_cond = hit && is_cond[bidx];
    assign pred_taken = MODE != 0 && hit && (!is_cond[bidx] || cnt[cidx][1]);
    assign pred_pc = pred_taken ? target[bidx] : if_pc + 32'd4;
    assign pred_ghr = ghr;
    // Truncating {history, bit} keeps the newest HIST_BITS bits, which also covers HIST_BITS = 1.
    assign ghr_next = (upd_valid && upd_mispredict) ? (upd_is_cond ? HIST_BITS'({upd_ghr, upd_taken}) : upd_ghr) :
                      (!stall && hit_cond) ? HIST_BITS'({ghr, pred_taken}) : ghr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            ghr   <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= 2'b01;
        end else begin
            if (upd_valid && upd_taken) valid[widx] <= 1'b1;
            if (upd_valid && upd_is_cond)
                cnt[uidx] <= upd_taken ? (cnt[uidx] == 2'b11 ? 2'b11 : cnt[uidx] + 2'd1)
                                       : (cnt[uidx] == 2'b00 ? 2'b00 : cnt[uidx] - 2'd1);
            if (MODE == 2) ghr <= ghr_next;
        end
    end
    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag[widx]     <= upd_pc[31:IDX+2];
            target[widx]  <= upd_target;
            is_cond[widx] <= upd_is_cond;
        end
    end
endmodule
